// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the prefetching fetch stage.
//               FETCH_XLEN must match the XLEN parameter of fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    // Canonical no-op (addi x0, x0, 0) shown on the instruction bus when idle.
    localparam logic [FETCH_XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    // Sequential fetch increment.
    localparam logic [FETCH_XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry synchronous FIFO of {PC, instruction} pairs with
//               push, pop, synchronous flush and occupancy count.
//               DEPTH must be a power of two (pointers wrap naturally).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // Pointers, count and storage; flush discards everything including a same-cycle push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Fetch stage with PC generation, credit-based requests to a
//               1-cycle-latency instruction memory, epoch tagging of the
//               in-flight request and a prefetch FIFO towards decode.
//               Optional macro FETCH_BYPASS_EN: a current-epoch response
//               arriving while the FIFO is empty is forwarded to decode in
//               the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    input  logic                     predict_redirect_i,
    input  logic [XLEN-1:0]          predict_pc_i,
    output logic                     imem_req_o,
    output logic [XLEN-1:0]          imem_addr_o,
    input  logic [XLEN-1:0]          imem_rdata_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          out_instr_o,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [XLEN-1:0]          out_pc_plus4_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int              CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]  c_depth = (CNT_W+1)'(DEPTH);

    logic              r_hold_req;
    logic [XLEN-1:0]   r_pc;
    logic              r_inflight;
    logic              r_inflight_epoch;
    logic [XLEN-1:0]   r_inflight_pc;
    logic              r_epoch;

    fetch_entry_t      w_head;
    fetch_entry_t      w_push_data;
    fetch_entry_t      w_out_entry;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_credit_used;
    logic              w_empty;
    logic              w_head_valid;
    logic              w_resp_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_req;
    logic              w_out_valid;

    assign w_head_valid = !w_empty;

    // A response is kept only if it belongs to the current epoch and no
    // redirect is flushing the queue this cycle.
    assign w_resp_valid = r_inflight && (r_inflight_epoch == r_epoch) && !redirect_i;
    assign w_push_data  = {r_inflight_pc, imem_rdata_i};

    // Slots already promised: stored entries plus the outstanding response.
    assign w_credit_used = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};

    // No request while the redirect is being taken: its response would land
    // after the flush and only waste a memory access.
    assign w_req = !r_hold_req && !redirect_i && ((w_credit_used < c_depth) || w_pop);

`ifdef FETCH_BYPASS_EN
    logic w_bypass;

    assign w_bypass = w_resp_valid && w_empty;
    assign w_push   = w_resp_valid && !(w_bypass && out_ready_i);
    assign w_pop    = w_head_valid && out_ready_i && !redirect_i;

    // Decode sees the FIFO head, or the live response when the FIFO is empty.
    always_comb begin
        w_out_entry = w_head;
        w_out_valid = w_head_valid;
        if (w_bypass) begin
            w_out_entry = w_push_data;
            w_out_valid = 1'b1;
        end
    end
`else
    assign w_push = w_resp_valid;
    assign w_pop  = w_head_valid && out_ready_i && !redirect_i;

    // Decode sees the registered FIFO head only.
    always_comb begin
        w_out_entry = w_head;
        w_out_valid = w_head_valid;
    end
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_i),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    // Suppress requests during reset and for the first cycle after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_req <= 1'b1;
        end else begin
            r_hold_req <= 1'b0;
        end
    end

    // Fetch PC: resolved redirect, then predictor, then sequential advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_i) begin
            r_pc <= redirect_pc_i;
        end else if (predict_redirect_i) begin
            r_pc <= predict_pc_i;
        end else if (w_req) begin
            r_pc <= r_pc + XLEN'(PC_STEP);
        end
    end

    // Track the single outstanding request with its PC and epoch tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_inflight_pc    <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_epoch <= r_epoch;
                r_inflight_pc    <= r_pc;
            end
        end
    end

    // Each resolved redirect starts a new epoch, invalidating older responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epoch <= 1'b0;
        end else if (redirect_i) begin
            r_epoch <= ~r_epoch;
        end
    end

    assign imem_req_o     = w_req;
    assign imem_addr_o    = r_pc;
    assign out_valid_o    = w_out_valid;
    assign out_instr_o    = w_out_valid ? w_out_entry.instr : INSTR_NOP;
    assign out_pc_o       = w_out_entry.pc;
    assign out_pc_plus4_o = w_out_entry.pc + PC_STEP;
    assign occupancy_o    = w_count;

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fetch_queue
// Description : Table-driven bench for fetch_queue (default build, bypass
//               disabled). Instruction memory returns addr + INSTR_TAG.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam logic [31:0] INSTR_TAG = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        predict_redirect_i;
    logic [31:0] predict_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_pc_plus4_o;
    logic [2:0]  occupancy_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        pr;
        logic [31:0] ppc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
        logic [2:0]  eocc;
    } vec_t;

    vec_t vecs[$];

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .redirect_i         (redirect_i),
        .redirect_pc_i      (redirect_pc_i),
        .predict_redirect_i (predict_redirect_i),
        .predict_pc_i       (predict_pc_i),
        .imem_req_o         (imem_req_o),
        .imem_addr_o        (imem_addr_o),
        .imem_rdata_i       (imem_rdata_i),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_instr_o        (out_instr_o),
        .out_pc_o           (out_pc_o),
        .out_pc_plus4_o     (out_pc_plus4_o),
        .occupancy_o        (occupancy_o)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory, one cycle read latency.
    always @(posedge clk) begin
        if (imem_req_o) imem_rdata_i <= imem_addr_o + INSTR_TAG;
    end

    task automatic check(input string name, input int cyc,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%h expected 0x%h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic rd, input logic [31:0] rpc,
                       input logic pr, input logic [31:0] ppc,
                       input logic ereq, input logic [31:0] eaddr,
                       input logic evalid, input logic [31:0] epc, input logic [2:0] eocc);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.rpc = rpc; v.pr = pr; v.ppc = ppc;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc; v.eocc = eocc;
        vecs.push_back(v);
    endtask

    initial begin
        redirect_i = 0; redirect_pc_i = 0; predict_redirect_i = 0; predict_pc_i = 0;
        out_ready_i = 0;

        // Cycle numbers count from reset release. Columns:
        // ready redirect rpc predict ppc | req addr valid pc occupancy
        add(1,0,0,0,0, 0,32'h0,  0,0,0);            // c0: no request right after reset
        add(1,0,0,0,0, 1,32'h0,  0,0,0);            // c1
        add(1,0,0,0,0, 1,32'h4,  0,0,0);            // c2
        add(1,0,0,0,0, 1,32'h8,  1,32'h0,1);        // c3: first output
        add(1,0,0,0,0, 1,32'hC,  1,32'h4,1);
        add(1,0,0,0,0, 1,32'h10, 1,32'h8,1);
        add(0,0,0,0,0, 1,32'h14, 1,32'hC,1);        // c6: decode stalls
        add(0,0,0,0,0, 1,32'h18, 1,32'hC,2);
        add(0,0,0,0,0, 0,32'h1C, 1,32'hC,3);        // credit exhausted (3 + 1 in flight)
        for (int i = 9; i <= 15; i++)
            add(0,0,0,0,0, 0,32'h1C, 1,32'hC,4);    // saturated, head stable
        add(1,0,0,0,0, 1,32'h1C, 1,32'hC,4);        // c16: pop frees a slot
        add(1,0,0,0,0, 1,32'h20, 1,32'h10,3);
        add(1,0,0,0,0, 1,32'h24, 1,32'h14,3);
        add(1,0,0,0,0, 1,32'h28, 1,32'h18,3);
        add(1,0,0,0,0, 1,32'h2C, 1,32'h1C,3);
        add(1,1,32'h100,0,0, 0,32'h30, 1,32'h20,3); // c21: redirect, 3 stored + 1 in flight
        add(1,0,0,0,0, 1,32'h100, 0,0,0);
        add(1,0,0,0,0, 1,32'h104, 0,0,0);
        add(1,0,0,0,0, 1,32'h108, 1,32'h100,1);
        add(1,1,32'h200,1,32'h300, 0,32'h10C, 1,32'h104,1); // c25: both redirects
        add(1,0,0,0,0, 1,32'h200, 0,0,0);
        add(1,0,0,0,0, 1,32'h204, 0,0,0);
        add(1,0,0,0,0, 1,32'h208, 1,32'h200,1);
        add(1,0,0,0,0, 1,32'h20C, 1,32'h204,1);
        add(1,0,0,1,32'h40, 1,32'h210, 1,32'h208,1); // c30: predict while fetching 0x210
        add(1,0,0,0,0, 1,32'h40, 1,32'h20C,1);
        add(1,0,0,0,0, 1,32'h44, 1,32'h210,1);
        add(1,0,0,0,0, 1,32'h48, 1,32'h40,1);
        add(1,0,0,0,0, 1,32'h4C, 1,32'h44,1);
        add(1,1,32'hFFFF_FFFC,0,0, 0,32'h50, 1,32'h48,1); // c35: redirect near top
        add(1,0,0,0,0, 1,32'hFFFF_FFFC, 0,0,0);
        add(1,0,0,0,0, 1,32'h0, 0,0,0);             // PC wrapped
        add(1,0,0,0,0, 1,32'h4, 1,32'hFFFF_FFFC,1); // plus4 wraps to 0
        add(1,0,0,0,0, 1,32'h8, 1,32'h0,1);

        // Reset state, observed while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("reset_req",   -1, {31'b0, imem_req_o},  32'h0);
        check("reset_valid", -1, {31'b0, out_valid_o}, 32'h0);
        check("reset_occ",   -1, {29'b0, occupancy_o}, 32'h0);
        check("reset_addr",  -1, imem_addr_o,          32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            out_ready_i        = vecs[i].rdy;
            redirect_i         = vecs[i].rd;
            redirect_pc_i      = vecs[i].rpc;
            predict_redirect_i = vecs[i].pr;
            predict_pc_i       = vecs[i].ppc;
            @(negedge clk);
            check("imem_req",  i, {31'b0, imem_req_o},  {31'b0, vecs[i].ereq});
            check("imem_addr", i, imem_addr_o,          vecs[i].eaddr);
            check("out_valid", i, {31'b0, out_valid_o}, {31'b0, vecs[i].evalid});
            check("occupancy", i, {29'b0, occupancy_o}, {29'b0, vecs[i].eocc});
            if (vecs[i].evalid) begin
                check("out_pc",    i, out_pc_o,       vecs[i].epc);
                check("out_pc+4",  i, out_pc_plus4_o, vecs[i].epc + 32'd4);
                check("out_instr", i, out_instr_o,    vecs[i].epc + INSTR_TAG);
            end
            @(posedge clk);
            #1;
        end
        out_ready_i = 0; redirect_i = 0; predict_redirect_i = 0;

        // Asynchronous reset mid-run: outputs clear without waiting for a clock.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_req",   100, {31'b0, imem_req_o},  32'h0);
        check("async_rst_valid", 100, {31'b0, out_valid_o}, 32'h0);
        check("async_rst_occ",   100, {29'b0, occupancy_o}, 32'h0);
        check("async_rst_addr",  100, imem_addr_o,          32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_hold", 101, {31'b0, imem_req_o}, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_req",  102, {31'b0, imem_req_o}, 32'h1);
        check("post_rst_addr", 102, imem_addr_o,         32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-entry fetch stage. Generates the fetch PC and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned {PC, instruction} pairs in a DEPTH-entry prefetch FIFO, so decode stalls no longer freeze instruction memory.
- Sits between PC redirect sources (execute-stage resolution, branch predictor) and the IF/ID register. Drives decode through a valid/ready handshake.

Parameters:
- XLEN, 32, address/instruction width.
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- redirect_i  in  1  resolved redirect (mispredict, jump, JALR) from execute; highest priority.
- redirect_pc_i  in  XLEN  target for redirect_i.
- predict_redirect_i  in  1  predictor-taken redirect; lower priority.
- predict_pc_i  in  XLEN  target for predict_redirect_i.
- imem_req_o  out  1  instruction memory read request this cycle.
- imem_addr_o  out  XLEN  request address (current fetch PC).
- imem_rdata_i  in  XLEN  read data; valid the cycle after an accepted request.
- out_valid_o  out  1  FIFO head holds a valid instruction.
- out_ready_i  in  1  decode accepts the head this cycle.
- out_instr_o  out  XLEN  head instruction.
- out_pc_o  out  XLEN  head PC.
- out_pc_plus4_o  out  XLEN  head PC + 4.
- occupancy_o  out  $clog2(DEPTH)+1  valid FIFO entries.

Behaviour:
- Reset (async, immediate):
  - fetch PC = RESET_PC.
  - FIFO empty; occupancy_o = 0; out_valid_o = 0.
  - In-flight flag cleared; epoch = 0.
  - imem_req_o = 0 during reset and in the first cycle after it.
- Credit rule: imem_req_o = 1 iff (occupancy + in_flight) < DEPTH, or a pop happens this cycle. A request is never issued without a guaranteed slot.
- On an issued request:
  - fetch PC <= PC + 4 (modulo 2^XLEN, wraps silently).
  - in_flight <= 1, tagged with the current epoch.
- Response: the cycle after a request, imem_rdata_i is pushed as {PC, instr} unless the tagged epoch ≠ current epoch. Stale responses are dropped silently.
- Pop: occurs when out_valid_o && out_ready_i. Push and pop in the same cycle leave occupancy unchanged. Pointers wrap modulo DEPTH.
- redirect_i = 1 (priority 1):
  - Next cycle: FIFO flushed, occupancy 0, epoch toggles, fetch PC = redirect_pc_i.
  - Any same-cycle pop is ignored, as is any same-cycle push of the old epoch.
  - A request is issued at redirect_pc_i in the following cycle.
- predict_redirect_i = 1 without redirect_i (priority 2):
  - Fetch PC <= predict_pc_i; the FIFO is not flushed.
  - Any in-flight response still pushes, because it belongs to the predicted path's predecessor.
- Both asserted: redirect_i wins; predict_redirect_i is ignored.
- Outputs are registered from the FIFO head. The head is stable while out_valid_o && !out_ready_i.
- Steady-state latency (request to out_valid_o) is 2 cycles. Throughput is 1 instruction/cycle when decode is always ready.
- Misaligned targets (bits [1:0] ≠ 0) are forwarded unchanged; exception handling is downstream.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty and a valid (current-epoch) response arrives, it drives out_* combinationally that same cycle (out_valid_o = 1).
  - If out_ready_i = 1, it is not written into the FIFO.
  - Redirect-to-decode latency drops from 2 to 1 cycles after the request.
- Undefined: all responses pass through the FIFO; outputs are purely registered.

Decomposition:
- fetch_pkg holds:
  - typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;}.
  - localparam INSTR_NOP = 32'h0000_0013.
  - localparam PC_STEP = 4.
- Sub-module fetch_fifo: generic DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, async active-high rst.
- fetch_queue owns PC, credit, epoch and redirect logic.

Test Plan:
- Reset, then out_ready_i=1 with imem returning addr-derived data → requests at 0x0, 0x4, 0x8…; first out_valid_o on cycle 3 after reset release, with out_pc_o=0x0 and out_pc_plus4_o=0x4; then one instruction per cycle.
- out_ready_i=0 for 10 cycles → occupancy_o saturates at DEPTH=4; imem_req_o=0 once occupancy+in_flight=4; no entry lost. When ready is restored, PCs 0x0–0xC drain in order.
- FIFO holding 3 entries plus one in flight, redirect_i with redirect_pc_i=0x100 → next cycle occupancy_o=0; stale response dropped; next imem_addr_o=0x100; first output PC is 0x100.
- redirect_i (0x200) and predict_redirect_i (0x300) in the same cycle → fetch PC 0x200; no output ever shows PC 0x300.
- predict_redirect_i to 0x40 while fetching 0x8 → entries 0x0, 0x4, 0x8 retained in order, followed by 0x40, 0x44.
- Fetch PC 0xFFFF_FFFC → the next request wraps to 0x0; out_pc_plus4_o=0x0 for the 0xFFFF_FFFC entry.
